// File: rtl/mat_transpose_vec_mult_seq_pkg.sv
// Shared types, constants and float32 arithmetic for the transpose
// matrix-vector multiplier.
package mat_transpose_vec_mult_seq_pkg;

  localparam int FP32_W = 32;
  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Subnormals flush to zero; exponent overflow saturates to infinity.
  function automatic logic [31:0] fp_mul(input logic [31:0] a,
                                         input logic [31:0] b);
    logic [47:0] p;
    logic [24:0] mr;
    logic        rnd;
    logic        s;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
      return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) e = e + 1;
    else p = p << 1;
    rnd = p[23] && (p[24] || (|p[22:0]));
    mr = {1'b0, p[47:24]} + 25'(rnd);
    if (mr[24]) begin
      mr = mr >> 1;
      e = e + 1;
    end
    if (e <= 0) return {s, 31'd0};
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, e[7:0], mr[22:0]};
  endfunction

  // Round-to-nearest-even with guard and sticky bits below the mantissa.
  function automatic logic [31:0] fp_add(input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] x;
    logic [31:0] y;
    logic [26:0] mx;
    logic [26:0] my;
    logic [26:0] sh;
    logic [27:0] s;
    logic [24:0] mr;
    logic        rnd;
    int          e;
    int          d;
    if (a[30:23] == 8'd0)
      return (b[30:23] == 8'd0) ? FP32_ZERO : b;
    if (b[30:23] == 8'd0)
      return a;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    e = int'(x[30:23]);
    d = e - int'(y[30:23]);
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    if (d > 26) begin
      sh = 27'd1;
    end else begin
      sh = my >> d;
      if ((my & ((27'd1 << d) - 27'd1)) != 27'd0)
        sh[0] = 1'b1;
    end
    if (x[31] == y[31]) begin
      s = {1'b0, mx} + {1'b0, sh};
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 1;
      end
    end else begin
      s = {1'b0, mx} - {1'b0, sh};
      if (s == 28'd0) return FP32_ZERO;
      for (int k = 0; k < 27; k++) begin
        if (!s[26]) begin
          s = s << 1;
          e = e - 1;
        end
      end
    end
    rnd = s[2] && (s[3] || s[1] || s[0]);
    mr = {1'b0, s[26:3]} + 25'(rnd);
    if (mr[24]) begin
      mr = mr >> 1;
      e = e + 1;
    end
    if (e <= 0) return {x[31], 31'd0};
    if (e >= 255) return {x[31], 8'hFF, 23'd0};
    return {x[31], e[7:0], mr[22:0]};
  endfunction

endpackage

// File: rtl/mat_transpose_vec_mult_seq_column_select.sv
// Gathers column j of a row-major L x M float32 matrix
// into an L-element packed vector.
module column_select
  import mat_transpose_vec_mult_seq_pkg::*;
#(
  parameter  int L  = 2,
  parameter  int M  = 3,
  localparam int JW = (M > 1) ? $clog2(M) : 1
) (
  input  logic [FP32_W*L*M-1:0] w,
  input  logic [JW-1:0]         j,
  output logic [FP32_W*L-1:0]   col
);

  always_comb begin
    col = '0;
    for (int i = 0; i < L; i++)
      col[FP32_W*i +: FP32_W] = w[FP32_W*(M*i + int'(j)) +: FP32_W];
  end

endmodule

// File: rtl/mat_transpose_vec_mult_seq_dot.sv
// Parallel float32 dot product, purely combinational.
// Products are accumulated in element order starting from +0.
module fp32_dot
  import mat_transpose_vec_mult_seq_pkg::*;
#(
  parameter int VLEN = 2
) (
  input  logic [FP32_W*VLEN-1:0] a,
  input  logic [FP32_W*VLEN-1:0] b,
  output logic [FP32_W-1:0]      y
);

  always_comb begin
    y = FP32_ZERO;
    for (int i = 0; i < VLEN; i++)
      y = fp_add(y, fp_mul(a[FP32_W*i +: FP32_W],
                           b[FP32_W*i +: FP32_W]));
  end

endmodule

// File: rtl/mat_transpose_vec_mult_seq.sv
// Y = W^T * D, one output element per clock.
// Optional per-element valid flags: MTVM_VALID_MASK_EN.
module mat_transpose_vec_mult_seq
  import mat_transpose_vec_mult_seq_pkg::*;
#(
  parameter int L = 2,
  parameter int M = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FP32_W*L*M-1:0] W,
  input  logic [FP32_W*L-1:0]   D,
  output logic [FP32_W*M-1:0]   Y,
  output logic                  busy,
  output logic                  done
`ifdef MTVM_VALID_MASK_EN
  ,
  output logic [M-1:0]          y_valid
`endif
);

  localparam int JW = (M > 1) ? $clog2(M) : 1;

  state_t              state;
  state_t              state_n;
  logic [JW-1:0]       j;
  logic [JW-1:0]       j_inc;
  logic [JW-1:0]       sel_j;
  logic [FP32_W*L-1:0] col_reg;
  logic [FP32_W*L-1:0] col_sel;
  logic [FP32_W*L-1:0] d_reg;
  logic [FP32_W-1:0]   dot;
  logic                load;
  logic                last;

  assign last  = (j == JW'(M - 1));
  assign j_inc = j + JW'(1);

  column_select #(
    .L(L),
    .M(M)
  ) u_col (
    .w  (W),
    .j  (sel_j),
    .col(col_sel)
  );

  fp32_dot #(
    .VLEN(L)
  ) u_dot (
    .a(col_reg),
    .b(d_reg),
    .y(dot)
  );

  // sel_j stays 0 unless advancing, so W is never indexed past column M-1
  always_comb begin
    state_n = state;
    load    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    sel_j   = '0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_n = S_DONE;
        else sel_j = j_inc;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_n = S_RUN;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      j       <= '0;
      col_reg <= '0;
      d_reg   <= '0;
      Y       <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        j       <= '0;
        col_reg <= col_sel;
        d_reg   <= D;
      end else if (busy) begin
        Y[FP32_W*int'(j) +: FP32_W] <= dot;
        if (!last) begin
          j       <= j_inc;
          col_reg <= col_sel;
        end
      end
    end
  end

`ifdef MTVM_VALID_MASK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= '0;
    end else if (load) begin
      y_valid <= '0;
    end else if (busy) begin
      y_valid[j] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mat_transpose_vec_mult_seq.sv
// Directed bench for mat_transpose_vec_mult_seq with a result scoreboard.
// Covers both the default build and MTVM_VALID_MASK_EN.
module tb_mat_transpose_vec_mult_seq;
  import mat_transpose_vec_mult_seq_pkg::*;

  localparam logic [31:0] F0  = 32'h0000_0000;
  localparam logic [31:0] F1  = 32'h3F80_0000;
  localparam logic [31:0] FM1 = 32'hBF80_0000;
  localparam logic [31:0] F2  = 32'h4000_0000;
  localparam logic [31:0] FM2 = 32'hC000_0000;
  localparam logic [31:0] F3  = 32'h4040_0000;
  localparam logic [31:0] F4  = 32'h4080_0000;
  localparam logic [31:0] F5  = 32'h40A0_0000;
  localparam logic [31:0] F6  = 32'h40C0_0000;
  localparam logic [31:0] F7  = 32'h40E0_0000;
  localparam logic [31:0] F9  = 32'h4110_0000;
  localparam logic [31:0] F10 = 32'h4120_0000;
  localparam logic [31:0] F12 = 32'h4140_0000;
  localparam logic [31:0] F15 = 32'h4170_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_a;
  logic         start_b;
  logic [191:0] w_a;
  logic [63:0]  d_a;
  logic [95:0]  y_a;
  logic         busy_a;
  logic         done_a;
  logic [127:0] w_b;
  logic [127:0] d_b;
  logic [31:0]  y_b;
  logic         busy_b;
  logic         done_b;
`ifdef MTVM_VALID_MASK_EN
  logic [2:0]   yv_a;
  logic [0:0]   yv_b;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  mat_transpose_vec_mult_seq #(.L(2), .M(3)) u_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_a),
    .W      (w_a),
    .D      (d_a),
    .Y      (y_a),
    .busy   (busy_a),
    .done   (done_a)
`ifdef MTVM_VALID_MASK_EN
    ,
    .y_valid(yv_a)
`endif
  );

  mat_transpose_vec_mult_seq #(.L(4), .M(1)) u_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_b),
    .W      (w_b),
    .D      (d_b),
    .Y      (y_b),
    .busy   (busy_b),
    .done   (done_b)
`ifdef MTVM_VALID_MASK_EN
    ,
    .y_valid(yv_b)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit sel_b, output int n);
    n = 0;
    while (!(sel_b ? done_b : done_a) && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic check_y_a(input string tag);
    logic [31:0] e;
    for (int j = 0; j < 3; j++) begin
      e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      chk($sformatf("%s_y%0d", tag, j), 128'(y_a[32*j +: 32]), 128'(e));
    end
  endtask

  initial begin
    int n;
    int pulses;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    w_a = {F6, F5, F4, F3, F2, F1};
    d_a = {F1, F1};
    w_b = {F4, F3, F2, F1};
    d_b = {F1, F1, F1, F1};
    step();
    step();
    chk("rst_y", 128'(y_a), 128'(0));
    chk("rst_busy", 128'(busy_a), 128'(0));
    chk("rst_done", 128'(done_a), 128'(0));
    rst_n = 1'b1;
    step();

    // basic run
    sb.push_back(F5);
    sb.push_back(F7);
    sb.push_back(F9);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("b_busy0", 128'(busy_a), 128'(1));
    chk("b_done0", 128'(done_a), 128'(0));
`ifdef MTVM_VALID_MASK_EN
    chk("b_yv0", 128'(yv_a), 128'(0));
`endif
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("b_done%0d", k), 128'(done_a), 128'(k == 3));
      chk($sformatf("b_busy%0d", k), 128'(busy_a), 128'(k < 3));
`ifdef MTVM_VALID_MASK_EN
      chk($sformatf("b_yv%0d", k), 128'(yv_a), 128'((1 << k) - 1));
`endif
    end
    check_y_a("basic");

    // back-to-back: start accepted from DONE
    d_a = {F0, F2};
    start_a = 1'b1;
    sb.push_back(F2);
    sb.push_back(F4);
    sb.push_back(F6);
    step();
    chk("bb_done", 128'(done_a), 128'(0));
    chk("bb_busy", 128'(busy_a), 128'(1));
`ifdef MTVM_VALID_MASK_EN
    chk("bb_yv", 128'(yv_a), 128'(0));
`endif
    wait_done(1'b0, n);
    chk("bb_gap", 128'(n), 128'(3));
    start_a = 1'b0;
    check_y_a("bb");
    step();
    chk("bb_idle_done", 128'(done_a), 128'(0));
    chk("bb_idle_busy", 128'(busy_a), 128'(0));

    // reset after Y[0] is written
    d_a = {F1, F1};
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    chk("mr_y0", 128'(y_a[31:0]), 128'(F5));
    rst_n = 1'b0;
    #1;
    chk("mr_y", 128'(y_a), 128'(0));
    chk("mr_busy", 128'(busy_a), 128'(0));
    chk("mr_done", 128'(done_a), 128'(0));
    chk("mr_state", 128'(u_a.state), 128'(S_IDLE));
    rst_n = 1'b1;
    step();
    sb.push_back(F5);
    sb.push_back(F7);
    sb.push_back(F9);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_done(1'b0, n);
    chk("mr_lat", 128'(n), 128'(3));
    check_y_a("mr");

    // start pulsed mid-run is ignored
    step();
    d_a = {F2, F1};
    sb.push_back(F9);
    sb.push_back(F12);
    sb.push_back(F15);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (done_a) pulses++;
      step();
    end
    chk("sr_pulses", 128'(pulses), 128'(1));
    check_y_a("sr");

    // M=1, L=4
    sb.push_back(F10);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("m1_busy", 128'(busy_b), 128'(1));
    wait_done(1'b1, n);
    chk("m1_lat", 128'(n), 128'(1));
    chk("m1_y", 128'(y_b), 128'((sb.size() > 0) ? sb.pop_front() : 0));
`ifdef MTVM_VALID_MASK_EN
    chk("m1_yv", 128'(yv_b), 128'(1));
`endif
    step();
    d_b = {FM1, F1, FM1, F1};
    sb.push_back(FM2);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    wait_done(1'b1, n);
    chk("m1n_lat", 128'(n), 128'(1));
    chk("m1n_y", 128'(y_b), 128'((sb.size() > 0) ? sb.pop_front() : 0));
    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mat_transpose_vec_mult_seq.md
# mat_transpose_vec_mult_seq

Sequential backward-pass multiplier: computes Y = Wᵀ · D, where W is an L × M float32 weight matrix (row-major, L outputs × M inputs) and D is an L-element error vector. It produces the M-element input-side gradient, one element per clock. It is the backward counterpart of the sequential forward matrix multiplier and reuses the same parallel float32 dot-product unit, instanced once with VLEN = L. It sits between a layer's error vector and the previous layer's backward stage.

## Interface
- L, 1, rows of W = length of D (layer outputs)
- M, 1, columns of W = length of Y (layer inputs)

Clock is `clk`; reset is `rst_n`, asynchronous, active-low.

- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- W  in  32·L·M  row-major float32 matrix; element (i,j) at bits [32·(M·i+j) +: 32]; must be held stable from the start edge until done
- D  in  32·L  float32 vector; element i at [32·i +: 32]; must be held stable like W
- Y  out  32·M  float32 result; element j at [32·j +: 32]
- busy  out  1  high in RUN
- done  out  1  high for exactly one cycle in DONE
- y_valid  out  M  per-element written flags; present only with MTVM_VALID_MASK_EN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - go to RUN with j←0.
  - Load the operand registers: col_reg←column 0 of W (W(i,0) for i=0..L-1, packed as element i), d_reg←D.
- RUN, each edge:
  - Y[j]←dot(col_reg, d_reg).
  - If j==M-1, go to DONE.
  - Otherwise j←j+1 and col_reg←column j+1.
- DONE:
  - done=1.
  - Next edge: if start=1, behave as IDLE+start (back-to-back); otherwise go to IDLE.
- start in RUN is ignored; no queuing.
- Y elements not yet rewritten in a new run keep their previous values. Y holds its final value indefinitely after done.
- Arithmetic:
  - IEEE-754 single precision, as produced by the shared dot-product unit.
  - No saturation and no NaN handling added by this block.
  - L=1 reduces to a scalar multiply per column.
- Counter j is wide enough for M-1 ($clog2(M), minimum 1 bit). It never exceeds M-1.
- Reset, at any time including mid-RUN:
  - state=IDLE, j=0, col_reg=0, d_reg=0, Y=0, busy=0, done=0, y_valid=0.
  - The partial run is abandoned.

## Timing
- Start sampled at edge E0. Y[j] is updated at edge E0+1+j. done is high during the cycle following edge E0+M.
- Throughput: one element per cycle.
- Back-to-back runs: one run every M+1 cycles.
- busy rises at E0 and falls at E0+M. busy and done are never high together.
- The dot-product unit is purely combinational between the operand registers and Y. Its path must meet one clock period for the chosen L.
- M=1: RUN lasts one cycle, and done is high in the cycle after E0+1.

## Configuration
- MTVM_VALID_MASK_EN defined:
  - y_valid port exists.
  - All bits clear on start acceptance.
  - Bit j sets at the same edge Y[j] is written.
  - All bits are 1 when done is high.
- Undefined: the port is absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - FP32_W = 32
  - FP32_ZERO = 32'h0000_0000
  - FSM state encoding (IDLE=0, RUN=1, DONE=2, 2 bits)
- Sub-module `column_select #(L, M)`:
  - Combinational gather of column j from row-major W into an L-element packed vector.
  - Instanced once, feeding col_reg.
- The dot-product unit is instanced once, VLEN = L.

## Test plan
- Basic run, L=2, M=3:
  - Stimulus: W=[[1,2,3],[4,5,6]], D=[1,1], start pulse.
  - Required: Y=[0x40A00000, 0x40E00000, 0x41100000] (5, 7, 9); done exactly M cycles after the start edge; busy high for 3 cycles.
- Back-to-back run:
  - Stimulus: start held high through DONE with D changed to [2,0].
  - Required: second run begins immediately; Y=[2,4,6]; done pulses twice, with spacing M+1=4 cycles.
- Mid-run reset:
  - Stimulus: rst_n low after Y[0] is written.
  - Required: Y=0, busy=0, state IDLE; the next start yields a correct full result.
- start during RUN:
  - Stimulus: start pulsed while busy.
  - Required: ignored; exactly one done pulse.
- M=1, L=4:
  - Stimulus: W=[1,2,3,4]ᵀ, D=[1,1,1,1].
  - Required: Y=0x41200000 (10); done one cycle after RUN.
- With MTVM_VALID_MASK_EN:
  - Required: y_valid steps 001→011→111 on successive edges; clears to 000 at the next start.
